// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential increment, branch/call/return with a circular
// return-address stack, exception entry/return and a sticky HALT state. Optional PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter int unsigned    PCW       = 32,
    parameter int unsigned    INC       = 4,
    parameter logic [PCW-1:0] RESET_PC  = '0,
    parameter logic [31:0]    EXC_VEC   = 32'h100,
    parameter int unsigned    RAS_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           halt,
    input  logic           stall,
    input  logic           branch,
    input  logic           call,
    input  logic           ret,
    input  logic           exc,
    input  logic           eret,
    input  logic [PCW-1:0] PC_branch,
    output logic [PCW-1:0] PC_out,
    output logic [PCW-1:0] epc,
    output logic           halted,
    output logic           ras_empty,
    output logic           ras_full,
    output logic           ras_underflow,
    output logic           misalign
);

    localparam int unsigned    AW         = $clog2(RAS_DEPTH);
    localparam logic [PCW-1:0] EXC_PC     = PCW'(EXC_VEC);
    localparam logic [PCW-1:0] STEP       = PCW'(INC);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(RAS_DEPTH);
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [PCW-1:0] ALIGN_MASK = PCW'(INC - 1);
`endif

    typedef enum logic {RUN, HALT} state_t;

    state_t         state, state_next;
    logic [PCW-1:0] ras_mem [RAS_DEPTH];
    logic [AW-1:0]  sp;      // next free slot; top of stack is sp-1
    logic [AW:0]    count;
    logic [PCW-1:0] pc_next, epc_next, target, ras_top, pc_seq;
    logic           redirect, want_push, want_pop, push, pop;
    logic           underflow_next, misalign_next;

    assign pc_seq    = PC_out + STEP;
    assign ras_top   = ras_mem[sp - AW'(1)];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == FULL_COUNT);
    assign halted    = (state == HALT);

    always_comb begin
        state_next     = state;
        pc_next        = PC_out;
        epc_next       = epc;
        target         = PC_branch;
        redirect       = 1'b0;
        want_push      = 1'b0;
        want_pop       = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        underflow_next = 1'b0;
        misalign_next  = 1'b0;

        if (state == HALT) begin
            if (exc) begin
                epc_next   = PC_out;
                pc_next    = EXC_PC;
                state_next = RUN;
            end
        end else if (exc) begin
            epc_next = PC_out;
            pc_next  = EXC_PC;
        end else if (eret) begin
            redirect = 1'b1;
            target   = epc;
        end else if (branch) begin
            redirect  = 1'b1;
            target    = PC_branch;
            want_push = call;
        end else if (ret) begin
            redirect = 1'b1;
            if (ras_empty) begin
                target         = PC_branch;
                underflow_next = 1'b1;
            end else begin
                target   = ras_top;
                want_pop = 1'b1;
            end
        end else if (halt) begin
            state_next = HALT;
        end else if (!stall) begin
            pc_next = pc_seq;
        end

        // A misaligned redirect target becomes an exception and leaves the stack untouched.
        if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
            if ((target & ALIGN_MASK) != '0) begin
                epc_next      = target;
                pc_next       = EXC_PC;
                misalign_next = 1'b1;
            end else begin
                pc_next = target;
                push    = want_push;
                pop     = want_pop;
            end
`else
            pc_next = target;
            push    = want_push;
            pop     = want_pop;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC_out        <= RESET_PC;
            epc           <= '0;
            sp            <= '0;
            count         <= '0;
            ras_underflow <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            PC_out        <= pc_next;
            epc           <= epc_next;
            ras_underflow <= underflow_next;
            misalign      <= misalign_next;
            if (push) begin
                sp <= sp + AW'(1);
                if (count != FULL_COUNT) count <= count + (AW + 1)'(1);
            end else if (pop) begin
                sp    <= sp - AW'(1);
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // NOTE: stack storage has no reset; validity is tracked solely by count, so contents are don't-care.
    always_ff @(posedge clk) begin
        if (rst_n && push) ras_mem[sp] <= pc_seq;
    end

endmodule
